mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-master, one-slave arbiter for the single data memory port. The IFU (read-only) and the LSU (read/write, driven by the MEM/WBU stage) share one memory request/response channel. The block serialises their transactions, holding one outstanding transaction at a time. Round-robin grant prevents the fetch or load/store path from starving the other.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; write mask is fixed at 8 bits, one per byte, low DATA_W/8 used

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
ifu_req_valid  input  1  IFU read request
ifu_req_ready  output  1  IFU request accepted this cycle
ifu_req_addr  input  ADDR_W  IFU read address
ifu_resp_valid  output  1  IFU read data valid, one-cycle pulse
ifu_resp_rdata  output  DATA_W  IFU read data
lsu_req_valid  input  1  LSU request
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_req_wen  input  1  1 = write, 0 = read
lsu_req_addr  input  ADDR_W  LSU address
lsu_req_wdata  input  DATA_W  LSU write data
lsu_req_wmask  input  8  LSU byte write mask
lsu_resp_valid  output  1  LSU response (read data or write done), one-cycle pulse
lsu_resp_rdata  output  DATA_W  LSU read data; 0 for writes
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_wen  output  1  write enable
mem_req_addr  output  ADDR_W  address
mem_req_wdata  output  DATA_W  write data
mem_req_wmask  output  8  byte mask
mem_resp_valid  input  1  memory response valid; masters always accept
mem_resp_rdata  input  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, WAIT. Owner register: IFU or LSU. last_grant register.
- Reset (async, rst=1): state=IDLE, owner=IFU, last_grant=IFU, latched request regs=0.
  - All valid/ready outputs are 0 while in reset. mem_req_* data outputs are 0.
- IDLE: request-ready is asserted combinationally for exactly one master.
  - Only IFU valid -> grant IFU. Only LSU valid -> grant LSU.
  - Both valid -> grant the master not equal to last_grant. LSU wins the first tie after reset.
  - On the grant cycle: the granted master's req_ready=1 and the handshake completes. The request is latched (IFU: wen=0, wdata=0, wmask=0). owner and last_grant are updated; next state=REQ.
  - The non-granted master sees req_ready=0 and must hold its request stable.
- REQ: mem_req_valid=1, driving the latched fields. Both req_ready=0.
  - mem_req_ready=1 -> WAIT. Otherwise hold, with all fields stable.
- WAIT: mem_req_valid=0.
  - On mem_resp_valid=1: the owner's resp_valid=1 in that same cycle (combinational). resp_rdata=mem_resp_rdata for reads, 0 for writes. Next state=IDLE.
  - The non-owner's resp_valid stays 0.
- Latency: accept at cycle N; mem_req_valid at N+1; earliest resp at N+2 with a zero-wait memory. Next grant at the cycle after resp.
- mem_resp_valid in IDLE or REQ is ignored; no pulse is forwarded to either master.
- A new request is never accepted in the same cycle as a response. One transaction is in flight at most.
- ifu_resp_rdata/lsu_resp_rdata are 0 whenever the corresponding resp_valid=0.
- Reset mid-transaction aborts: the FSM returns to IDLE and no response is delivered. The memory model and masters are reset by the same rst.
- A master that drops req_valid before ready is legal; nothing is latched.

Test Plan:
- Reset: rst=1 asynchronously mid-REQ -> all valid/ready outputs 0 immediately; state IDLE after release; no resp pulse.
- IFU only, addr=0x80000000, zero-wait memory returning 0x00000413 -> ifu_req_ready at cycle 0, mem_req_valid at cycle 1 with wen=0, ifu_resp_valid pulse at cycle 2 with rdata=0x00000413.
- LSU write, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, with mem_req_ready held low 3 cycles -> mem_req fields stable for 4 cycles; lsu_resp_valid=1 with rdata=0.
- Both masters request continuously after reset -> grant order LSU, IFU, LSU, IFU. The non-owner never sees resp_valid.
- Spurious mem_resp_valid in IDLE -> no resp pulse to either master; the next transaction completes normally.
- LSU read where memory delays resp 5 cycles -> IFU request is held off (ifu_req_ready=0) until the cycle after lsu_resp_valid, then granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU read-only, LSU read/write) arbiter for the
// single data memory port. One transaction is in flight at a time. When
// both masters request together, the grant alternates so that neither the
// fetch path nor the load/store path can starve the other.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_wen,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [7:0]        lsu_req_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    // Only the low DATA_W/8 mask bits correspond to real bytes.
    localparam int BYTES = DATA_W / 8;
    localparam logic [7:0] MASK_USED = (BYTES >= 8) ? 8'hFF : 8'((9'd1 << BYTES) - 9'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef enum logic {
        M_IFU,
        M_LSU
    } master_t;

    state_t            r_state;
    master_t           r_owner;
    master_t           r_lastGrant;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wmask;

    logic w_grantIfu;
    logic w_grantLsu;
    logic w_idle;
    logic w_respFire;

    // On a tie the master that did not win last time is chosen; the two
    // grant terms are mutually exclusive by construction.
    assign w_grantIfu = ifu_req_valid && (!lsu_req_valid || (r_lastGrant == M_LSU));
    assign w_grantLsu = lsu_req_valid && (!ifu_req_valid || (r_lastGrant == M_IFU));

    // Ready and response pulses are gated by rst so that nothing handshakes
    // while the block is held in reset.
    assign w_idle     = (r_state == S_IDLE) && !rst;
    assign w_respFire = (r_state == S_WAIT) && mem_resp_valid && !rst;

    assign ifu_req_ready  = w_idle && w_grantIfu;
    assign lsu_req_ready  = w_idle && w_grantLsu;

    assign ifu_resp_valid = w_respFire && (r_owner == M_IFU);
    assign lsu_resp_valid = w_respFire && (r_owner == M_LSU);
    assign ifu_resp_rdata = ifu_resp_valid ? mem_resp_rdata : '0;
    assign lsu_resp_rdata = (lsu_resp_valid && !r_wen) ? mem_resp_rdata : '0;

    assign mem_req_valid  = (r_state == S_REQ);
    assign mem_req_wen    = r_wen;
    assign mem_req_addr   = r_addr;
    assign mem_req_wdata  = r_wdata;
    assign mem_req_wmask  = r_wmask;

    // Transaction FSM: latch the granted request, present it to memory,
    // then wait for the response before accepting anything new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= M_IFU;
            r_lastGrant <= M_IFU;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantLsu) begin
                        r_state     <= S_REQ;
                        r_owner     <= M_LSU;
                        r_lastGrant <= M_LSU;
                        r_wen       <= lsu_req_wen;
                        r_addr      <= lsu_req_addr;
                        r_wdata     <= lsu_req_wdata;
                        r_wmask     <= lsu_req_wmask & MASK_USED;
                    end else if (w_grantIfu) begin
                        r_state     <= S_REQ;
                        r_owner     <= M_IFU;
                        r_lastGrant <= M_IFU;
                        r_wen       <= 1'b0;
                        r_addr      <= ifu_req_addr;
                        r_wdata     <= '0;
                        r_wmask     <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
